// File: rtl/serial_equal_pkg.sv
// Shared types for the bit-serial equality front end.
// The FSM state encoding lives here so the top and any future users agree on it.
package serial_equal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial-in, parallel-out shift register used for each operand.
// A synchronous clear empties the word at the start of every compare.
module serial_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_out <= '0;
    end else if (clr) begin
      q_out <= '0;
    end else if (en) begin
      q_out <= {q_out[WIDTH-2:0], d_in};
    end
  end

endmodule

// File: rtl/serial_equal.sv
// Bit-serial word equality comparator front end: shifts in two operands MSB-first,
// tracks equality and the highest differing bit, and hands the result over a done/ack handshake.
module serial_equal
  import serial_equal_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             bit_valid_in,
  input  logic             a_bit_in,
  input  logic             b_bit_in,
  output logic             busy_out,
  output logic             done_out,
  input  logic             done_ack_in,
  output logic             eq_out,
  output logic [CNT_W-1:0] mismatch_idx_out,
  output logic [WIDTH-1:0] a_word_out,
  output logic [WIDTH-1:0] b_word_out
);

  cmp_state_t       state;
  logic [CNT_W-1:0] count;
  logic             eq_acc;
  logic [CNT_W-1:0] mis_idx;

  logic             accept;
  logic             last_bit;
  logic             bit_diff;
  logic             eq_next;
  logic [CNT_W-1:0] idx_next;
  logic             clr_words;

  assign accept    = (state == SHIFT) && bit_valid_in;
  assign last_bit  = accept && (count == CNT_W'(WIDTH - 1));
  assign bit_diff  = a_bit_in ^ b_bit_in;
  assign eq_next   = eq_acc & ~bit_diff;
  // Only the first mismatch is recorded; eq_acc stays high while every earlier bit pair matched.
  assign idx_next  = (eq_acc && bit_diff) ? (CNT_W'(WIDTH - 1) - count) : mis_idx;
  assign clr_words = (state == IDLE) && start_in;

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_words),
    .en    (accept),
    .d_in  (a_bit_in),
    .q_out (a_word_out)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_words),
    .en    (accept),
    .d_in  (b_bit_in),
    .q_out (b_word_out)
  );

  // Result outputs are loaded once on the final accepted bit and held through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      eq_acc           <= 1'b1;
      mis_idx          <= CNT_W'(WIDTH);
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      eq_out           <= 1'b0;
      mismatch_idx_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= SHIFT;
            busy_out <= 1'b1;
            count    <= '0;
            eq_acc   <= 1'b1;
            mis_idx  <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          if (bit_valid_in) begin
            count   <= count + CNT_W'(1);
            eq_acc  <= eq_next;
            mis_idx <= idx_next;
            if (last_bit) begin
              state            <= DONE;
              busy_out         <= 1'b0;
              done_out         <= 1'b1;
              eq_out           <= eq_next;
              mismatch_idx_out <= idx_next;
            end
          end
        end
        DONE: begin
          if (done_ack_in) begin
            state    <= IDLE;
            done_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
